// File: rtl/calc_hist.sv
// Button/switch accumulator calculator with overflow/zero flags and a
// DEPTH-entry undo history (circular LIFO, oldest entry dropped when full).
module calc_hist #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int SHW = $clog2(WIDTH),
  localparam int CW  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             btnu,
  input  logic             btnd,
  input  logic             btnl,
  input  logic             btnc,
  input  logic             btnr,
  input  logic             undo,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] led,
  output logic             ovf,
  output logic             zero,
  output logic [CW-1:0]    hist_cnt
);

  localparam int PW = $clog2(DEPTH);

  logic             btnd_q;
  logic             undo_q;
  logic             exec;
  logic             undo_p;
  logic [2:0]       op;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] res;
  logic             res_ovf;
  logic [SHW-1:0]   sh;
  logic             slt;
  logic [WIDTH-1:0] hist [DEPTH];
  logic [PW-1:0]    top;
  logic [PW-1:0]    top_inc;
  logic [PW-1:0]    top_dec;

  assign exec   = btnd & ~btnd_q;
  assign undo_p = undo & ~undo_q;
  assign op     = {btnl, btnc, btnr};
  assign sh     = sw[SHW-1:0];
  assign slt    = $signed(acc) < $signed(sw);

  // top points at the next free slot; both neighbours wrap at DEPTH
  assign top_inc = (top == PW'(DEPTH - 1)) ? '0 : top + PW'(1);
  assign top_dec = (top == '0) ? PW'(DEPTH - 1) : top - PW'(1);

  always_comb begin
    res     = '0;
    res_ovf = 1'b0;
    case (op)
      3'b000: res = acc & sw;
      3'b001: res = acc | sw;
      3'b010: begin
        res     = acc + sw;
        res_ovf = (acc[WIDTH-1] == sw[WIDTH-1]) & (res[WIDTH-1] != acc[WIDTH-1]);
      end
      3'b011: begin
        res     = acc - sw;
        res_ovf = (acc[WIDTH-1] != sw[WIDTH-1]) & (res[WIDTH-1] != acc[WIDTH-1]);
      end
      3'b100: res = {{(WIDTH-1){1'b0}}, slt};
      3'b101: res = acc << sh;
      3'b110: res = WIDTH'($signed(acc) >>> sh);
      default: res = acc ^ sw;
    endcase
  end

  always_ff @(posedge clk) begin
    btnd_q <= btnd;
    undo_q <= undo;
    if (btnu) begin
      acc      <= '0;
      ovf      <= 1'b0;
      top      <= '0;
      hist_cnt <= '0;
    end else if (exec) begin
      hist[top] <= acc;
      acc       <= res;
      ovf       <= res_ovf;
      top       <= top_inc;
      if (hist_cnt != CW'(DEPTH))
        hist_cnt <= hist_cnt + CW'(1);
    end else if (undo_p && hist_cnt != '0) begin
      acc      <= hist[top_dec];
      ovf      <= 1'b0;
      top      <= top_dec;
      hist_cnt <= hist_cnt - CW'(1);
    end
  end

  assign led  = acc;
  assign zero = (acc == '0);

endmodule

// File: tb/tb_calc_hist.sv
// Bench for calc_hist: 16-bit instance checked every cycle against a queue
// model plus literal expectations; 8-bit instance checked with literals.
module tb_calc_hist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 16-bit instance
  logic        btnu = 1'b0, btnd = 1'b0, undo = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [15:0] sw = '0;
  logic [15:0] led;
  logic        ovf, zero;
  logic [2:0]  hist_cnt;

  calc_hist #(.WIDTH(16), .DEPTH(4)) dut (
    .clk(clk), .btnu(btnu), .btnd(btnd), .btnl(op[2]), .btnc(op[1]), .btnr(op[0]),
    .undo(undo), .sw(sw), .led(led), .ovf(ovf), .zero(zero), .hist_cnt(hist_cnt)
  );

  // 8-bit instance
  logic       u8 = 1'b0, d8 = 1'b0, n8 = 1'b0;
  logic [2:0] op8 = 3'b000;
  logic [7:0] sw8 = '0;
  logic [7:0] led8;
  logic       ovf8, zero8;
  logic [2:0] cnt8;

  calc_hist #(.WIDTH(8), .DEPTH(4)) dut8 (
    .clk(clk), .btnu(u8), .btnd(d8), .btnl(op8[2]), .btnc(op8[1]), .btnr(op8[0]),
    .undo(n8), .sw(sw8), .led(led8), .ovf(ovf8), .zero(zero8), .hist_cnt(cnt8)
  );

  localparam logic [2:0] AND_ = 3'd0, OR_ = 3'd1, ADD = 3'd2, SUB = 3'd3,
                         SLT = 3'd4, LSL = 3'd5, ASR = 3'd6, XOR_ = 3'd7;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model of the 16-bit instance
  logic [15:0] m_acc = '0;
  bit          m_ovf = 1'b0;
  logic [15:0] m_hist[$];
  bit          m_bd_q = 1'b0, m_un_q = 1'b0;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    int sa, sb, s, n;
    sa = int'($signed(m_acc));
    sb = int'($signed(sw));
    n  = int'(sw) % 16;
    if (btnu) begin
      m_acc = '0;
      m_ovf = 1'b0;
      m_hist.delete();
    end else if (btnd && !m_bd_q) begin
      m_hist.push_back(m_acc);
      if (m_hist.size() > 4) void'(m_hist.pop_front());
      m_ovf = 1'b0;
      case (op)
        AND_: m_acc = m_acc & sw;
        OR_:  m_acc = m_acc | sw;
        ADD: begin s = sa + sb; m_ovf = (s > 32767) || (s < -32768); m_acc = 16'(s); end
        SUB: begin s = sa - sb; m_ovf = (s > 32767) || (s < -32768); m_acc = 16'(s); end
        SLT:  m_acc = (sa < sb) ? 16'd1 : 16'd0;
        LSL:  m_acc = 16'((int'(m_acc) << n) & 32'hFFFF);
        ASR:  m_acc = 16'((sa >>> n) & 32'hFFFF);
        default: m_acc = m_acc ^ sw;
      endcase
    end else if (undo && !m_un_q && m_hist.size() > 0) begin
      m_acc = m_hist.pop_back();
      m_ovf = 1'b0;
    end
    m_bd_q = btnd;
    m_un_q = undo;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mdl_led", 32'(led), 32'(m_acc));
      chk("mdl_ovf", 32'(ovf), 32'(m_ovf));
      chk("mdl_zero", 32'(zero), 32'(m_acc == 16'h0));
      chk("mdl_cnt", 32'(hist_cnt), 32'(m_hist.size()));
    end
  end

  task automatic reset16();
    @(posedge clk); #1 btnu = 1'b1;
    @(posedge clk); #1 btnu = 1'b0;
  endtask

  task automatic press(input logic [2:0] o, input logic [15:0] b, input logic [15:0] exp);
    @(posedge clk); #1 op = o; sw = b; btnd = 1'b1;
    @(posedge clk); #1 btnd = 1'b0;
    chk("press_led", 32'(led), 32'(exp));
  endtask

  task automatic do_undo(input logic [15:0] exp, input logic [2:0] ecnt);
    @(posedge clk); #1 undo = 1'b1;
    @(posedge clk); #1 undo = 1'b0;
    chk("undo_led", 32'(led), 32'(exp));
    chk("undo_cnt", 32'(hist_cnt), 32'(ecnt));
  endtask

  task automatic press8(input logic [2:0] o, input logic [7:0] b);
    @(posedge clk); #1 op8 = o; sw8 = b; d8 = 1'b1;
    @(posedge clk); #1 d8 = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    reset16();
    chk_en = 1'b1;
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_zero", 32'(zero), 32'h1);
    chk("rst_ovf", 32'(ovf), 32'h0);
    chk("rst_cnt", 32'(hist_cnt), 32'h0);

    // Operation sweep
    press(ADD, 16'h354A, 16'h354A);
    press(SUB, 16'h1234, 16'h2316);
    press(OR_, 16'h1001, 16'h3317);
    press(AND_, 16'hF0F0, 16'h3010);
    press(XOR_, 16'h1FA2, 16'h2FB2);
    press(ADD, 16'h6AA2, 16'h9A54);
    chk("sweep_ovf_add", 32'(ovf), 32'h1);
    press(LSL, 16'h0004, 16'hA540);
    chk("sweep_ovf_lsl", 32'(ovf), 32'h0);
    press(ASR, 16'h0001, 16'hD2A0);
    press(SLT, 16'h46FF, 16'h0001);
    chk("sweep_zero", 32'(zero), 32'h0);

    // Held execute button fires once
    reset16();
    @(posedge clk); #1 op = ADD; sw = 16'h0001; btnd = 1'b1;
    repeat (5) @(posedge clk);
    #1 btnd = 1'b0;
    chk("held_led", 32'(led), 32'h0001);
    chk("held_cnt", 32'(hist_cnt), 32'h1);
    press(ADD, 16'h0001, 16'h0002);

    // Undo with history overflow
    reset16();
    for (int i = 1; i <= 6; i++) press(ADD, 16'h0001, 16'(i));
    chk("full_cnt", 32'(hist_cnt), 32'h4);
    do_undo(16'h0005, 3'd3);
    do_undo(16'h0004, 3'd2);
    do_undo(16'h0003, 3'd1);
    do_undo(16'h0002, 3'd0);
    do_undo(16'h0002, 3'd0);

    // Execute and undo edges in the same cycle
    @(posedge clk); #1 op = ADD; sw = 16'h0010; btnd = 1'b1; undo = 1'b1;
    @(posedge clk); #1 btnd = 1'b0; undo = 1'b0;
    chk("simul_led", 32'(led), 32'h0012);
    chk("simul_cnt", 32'(hist_cnt), 32'h1);
    repeat (2) @(posedge clk);
    #1 chk("simul_hold", 32'(led), 32'h0012);

    // 8-bit instance: overflow and reset priority
    @(posedge clk); #1 u8 = 1'b1;
    @(posedge clk); #1 u8 = 1'b0;
    press8(ADD, 8'h7F);
    press8(ADD, 8'h01);
    chk("w8_led", 32'(led8), 32'h80);
    chk("w8_ovf", 32'(ovf8), 32'h1);
    chk("w8_zero", 32'(zero8), 32'h0);
    @(posedge clk); #1 u8 = 1'b1; d8 = 1'b1; sw8 = 8'h05;
    @(posedge clk); #1 u8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("w8_rst_led", 32'(led8), 32'h00);
    chk("w8_rst_ovf", 32'(ovf8), 32'h0);
    chk("w8_rst_cnt", 32'(cnt8), 32'h0);
    chk("w8_rst_zero", 32'(zero8), 32'h1);
    d8 = 1'b0;
    press8(ADD, 8'h01);
    chk("w8_repress", 32'(led8), 32'h01);
    chk("w8_repress_cnt", 32'(cnt8), 32'h1);

    @(posedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
